// File: rtl/bcd_countdown_timer.sv
// Mixed-radix BCD countdown timer with start/stop/load control and a one-cycle done pulse.
// Optional macro TIMER_AUTO_RELOAD_EN reloads the programmed value on terminal count instead of expiring.
module bcd_countdown_timer #(
    parameter int                        NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0]   DIGIT_MAX  = 16'h9959
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   prog,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      running,
    output logic                      expired,
    output logic                      done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_EXPIRED
    } state_e;

    state_e                    state_q, state_d;
    logic [4*NUM_DIGITS-1:0]   count_q, count_d;
    logic                      done_q, done_d;

    logic [4*NUM_DIGITS-1:0]   prog_clamped;
    logic [4*NUM_DIGITS-1:0]   dec_count;
    logic                      dec_zero;
    logic                      borrow;

    // Out-of-range programmed digits (including A-F) saturate at that digit's maximum.
    always_comb begin
        prog_clamped = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (prog[4*k +: 4] > DIGIT_MAX[4*k +: 4])
                prog_clamped[4*k +: 4] = DIGIT_MAX[4*k +: 4];
            else
                prog_clamped[4*k +: 4] = prog[4*k +: 4];
        end
    end

    // Digit k moves only when every lower digit is zero; a zero digit wraps to its own maximum.
    always_comb begin
        dec_count = count_q;
        borrow    = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0)
                    dec_count[4*k +: 4] = DIGIT_MAX[4*k +: 4];
                else
                    dec_count[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
            end
            borrow = borrow & (count_q[4*k +: 4] == 4'd0);
        end
        dec_zero = (dec_count == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = prog_clamped;
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUNNING)
                state_d = ST_PAUSED;
        end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
            if (count_q != '0) begin
                state_d = ST_RUNNING;
            end else begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end
        end else if (tick && state_q == ST_RUNNING) begin
`ifdef TIMER_AUTO_RELOAD_EN
            if (dec_zero) begin
                done_d = 1'b1;
                if (prog_clamped != '0) begin
                    count_d = prog_clamped;
                end else begin
                    count_d = dec_count;
                    state_d = ST_EXPIRED;
                end
            end else begin
                count_d = dec_count;
            end
`else
            count_d = dec_count;
            if (dec_zero) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        count   = count_q;
        running = (state_q == ST_RUNNING);
        expired = (state_q == ST_EXPIRED);
        done    = done_q;
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: table-driven control vectors plus
// hand-written terminal-count sequences modelled from an independent seconds counter.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset, tick, start, stop, load;
    logic [15:0] prog;
    logic [15:0] count;
    logic        running, expired, done;

    int checks   = 0;
    int failures = 0;

    bcd_countdown_timer dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .load    (load),
        .prog    (prog),
        .count   (count),
        .running (running),
        .expired (expired),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        ld;
        logic        st;
        logic        sp;
        logic        tk;
        logic [15:0] prg;
        logic [15:0] e_count;
        logic        e_run;
        logic        e_exp;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] e_count,
                             input logic e_run, input logic e_exp, input logic e_done);
        check({name, ".count"},   count,          e_count);
        check({name, ".running"}, {15'd0, running}, {15'd0, e_run});
        check({name, ".expired"}, {15'd0, expired}, {15'd0, e_exp});
        check({name, ".done"},    {15'd0, done},    {15'd0, e_done});
    endtask

    task automatic cycle(input logic rst_n, input logic ld, input logic st,
                         input logic sp, input logic tk, input logic [15:0] prg);
        reset = rst_n; load = ld; start = st; stop = sp; tick = tk; prog = prg;
        @(posedge clk);
        #1;
    endtask

    // Converts a remaining-seconds value into MM:SS BCD.
    function automatic logic [15:0] to_mmss(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; prog = '0;

        //               name           rst ld st sp tk prog      count    run exp done
        vecs.push_back('{"reset0",      0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
        vecs.push_back('{"reset1",      0, 0, 0, 0, 1, 16'h1234, 16'h0000, 0, 0, 0});
        vecs.push_back('{"clamp0A7F",   1, 1, 0, 0, 0, 16'h0A7F, 16'h0959, 0, 0, 0});
        vecs.push_back('{"load0100",    1, 1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0});
        vecs.push_back('{"start",       1, 0, 1, 0, 0, 16'h0100, 16'h0100, 1, 0, 0});
        vecs.push_back('{"stop_tick",   1, 0, 0, 1, 1, 16'h0100, 16'h0100, 0, 0, 0});
        vecs.push_back('{"paused_tick", 1, 0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 0});
        vecs.push_back('{"resume",      1, 0, 1, 0, 0, 16'h0100, 16'h0100, 1, 0, 0});
        vecs.push_back('{"tick_0059",   1, 0, 0, 0, 1, 16'h0100, 16'h0059, 1, 0, 0});
        vecs.push_back('{"start_held",  1, 0, 1, 0, 1, 16'h0100, 16'h0058, 1, 0, 0});
        vecs.push_back('{"load_run",    1, 1, 0, 0, 1, 16'h0102, 16'h0102, 0, 0, 0});
        vecs.push_back('{"load0000",    1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
        vecs.push_back('{"start_stop",  1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0});
        vecs.push_back('{"start_zero",  1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1});
        vecs.push_back('{"done_drop",   1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0});
        vecs.push_back('{"exp_start",   1, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0});
        vecs.push_back('{"exp_stop",    1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1, 0});
        vecs.push_back('{"clampFFFF",   1, 1, 0, 0, 0, 16'hFFFF, 16'h9959, 0, 0, 0});
        vecs.push_back('{"start9959",   1, 0, 1, 0, 0, 16'hFFFF, 16'h9959, 1, 0, 0});
        vecs.push_back('{"tick9958",    1, 0, 0, 0, 1, 16'hFFFF, 16'h9958, 1, 0, 0});
        vecs.push_back('{"reset_load",  0, 1, 0, 0, 1, 16'h1234, 16'h0000, 0, 0, 0});
        vecs.push_back('{"post_reset",  1, 0, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst_n, vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].tk, vecs[i].prg);
            check_all(vecs[i].name, vecs[i].e_count, vecs[i].e_run, vecs[i].e_exp, vecs[i].e_done);
        end

        // 1:02 countdown through minute borrow down to terminal count.
        cycle(1, 1, 0, 0, 0, 16'h0102);
        cycle(1, 0, 1, 0, 0, 16'h0102);
        check_all("run0102", 16'h0102, 1, 0, 0);
        for (int t = 1; t <= 61; t++) begin
            cycle(1, 0, 0, 0, 1, 16'h0102);
            check("cnt_tick", count, to_mmss(62 - t));
            check("done_low", {15'd0, done}, 16'd0);
        end
        cycle(1, 0, 0, 0, 1, 16'h0102);
`ifdef TIMER_AUTO_RELOAD_EN
        check_all("terminal_reload", 16'h0102, 1, 0, 1);
        cycle(1, 0, 0, 0, 0, 16'h0102);
        check_all("after_reload", 16'h0102, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 16'h0102);
        check_all("reload_tick", 16'h0101, 1, 0, 0);
`else
        check_all("terminal", 16'h0000, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 16'h0102);
        check_all("after_terminal", 16'h0000, 0, 1, 0);
        for (int t = 0; t < 3; t++) begin
            cycle(1, 0, 0, 0, 1, 16'h0102);
            check_all("exp_hold", 16'h0000, 0, 1, 0);
        end
`endif

        // Terminal count with prog zeroed before the last tick always expires.
        cycle(1, 1, 0, 0, 0, 16'h0003);
        cycle(1, 0, 1, 0, 0, 16'h0003);
        cycle(1, 0, 0, 0, 1, 16'h0003);
        check_all("p3_t1", 16'h0002, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 16'h0003);
        check_all("p3_t2", 16'h0001, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 16'h0000);
        check_all("p0_term", 16'h0000, 0, 1, 1);
        cycle(1, 0, 0, 0, 0, 16'h0000);
        check_all("p0_after", 16'h0000, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
